// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack
//   Unpacks three raw IEEE-754 operands (half, single or double) into 16-bit
//   class words {is_zero,is_norm,is_inf,is_nan,sign,exp[10:0]} plus a
//   right-justified {hidden,frac} mantissa. The pipeline has two stages with
//   valid/ready flow control. Stage 1 captures the raw fields and stage 2
//   classifies them onto the output registers.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand-set handshake
//   precision                11 double, 10 single, 01 half, 00 double
//   in_tag                   opaque tag carried with the set
//   a_raw, b_raw, c_raw      raw operands (narrow formats use the low bits)
//   out_valid/out_ready      result handshake
//   a/b/c_cls, a/b/c_man     class words and mantissas
//   out_prec, out_tag        precision and tag of the result set
//   snan_flag, clr_flags     sticky signalling-NaN flag and its clear

// Per-operand datapath: stage-1 field extract plus stage-2 classify.
module fp_unpack_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        s1_en,
  input  logic        s2_en,
  input  logic [1:0]  prec_in,
  input  logic [1:0]  s1_prec,
  input  logic [63:0] raw,
  output logic        snan,
  output logic [15:0] cls,
  output logic [52:0] man
);
  logic        sign_d, sign_q;
  logic [10:0] exp_d, exp_q;
  logic [51:0] frac_d, frac_q;
  logic [15:0] cls_d, cls_q;
  logic [52:0] man_d, man_q;
  logic [10:0] emax;
  logic        frac_msb, is_zero, is_norm, is_inf, is_nan;

  always_comb begin
    sign_d = raw[63];
    exp_d  = raw[62:52];
    frac_d = raw[51:0];
    case (prec_in)
      2'b01: begin
        sign_d = raw[15];
        exp_d  = {6'd0, raw[14:10]};
        frac_d = {42'd0, raw[9:0]};
      end
      2'b10: begin
        sign_d = raw[31];
        exp_d  = {3'd0, raw[30:23]};
        frac_d = {29'd0, raw[22:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    emax     = 11'h7FF;
    frac_msb = frac_q[51];
    case (s1_prec)
      2'b01: begin emax = 11'h01F; frac_msb = frac_q[9];  end
      2'b10: begin emax = 11'h0FF; frac_msb = frac_q[22]; end
      default: ;
    endcase
    is_zero = (exp_q == 11'd0) && (frac_q == 52'd0);
    is_norm = (exp_q != 11'd0) && (exp_q != emax);
    is_inf  = (exp_q == emax) && (frac_q == 52'd0);
    is_nan  = (exp_q == emax) && (frac_q != 52'd0);
    // quiet bit clear marks a signalling NaN
    snan    = is_nan & ~frac_msb;
    cls_d   = {is_zero, is_norm, is_inf, is_nan, sign_q, exp_q};
    // hidden bit sits just above the format's fraction, not at bit 52
    man_d   = {is_norm, frac_q};
    case (s1_prec)
      2'b01:   man_d = {42'd0, is_norm, frac_q[9:0]};
      2'b10:   man_d = {29'd0, is_norm, frac_q[22:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      frac_q <= '0;
      cls_q  <= '0;
      man_q  <= '0;
    end else begin
      if (s1_en) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        frac_q <= frac_d;
      end
      if (s2_en) begin
        cls_q <= cls_d;
        man_q <= man_d;
      end
    end
  end

  assign cls = cls_q;
  assign man = man_q;
endmodule

module fp_operand_unpack #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      precision,
  input  logic [TAGW-1:0] in_tag,
  input  logic [63:0]     a_raw,
  input  logic [63:0]     b_raw,
  input  logic [63:0]     c_raw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     a_cls,
  output logic [15:0]     b_cls,
  output logic [15:0]     c_cls,
  output logic [52:0]     a_man,
  output logic [52:0]     b_man,
  output logic [52:0]     c_man,
  output logic [1:0]      out_prec,
  output logic [TAGW-1:0] out_tag,
  output logic            snan_flag,
  input  logic            clr_flags
);
  localparam int NUM_LANES = 3;

  logic                  s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic                  s1_load, s2_load, snan_d, snan_q;
  logic [1:0]            s1_prec_d, s1_prec_q, out_prec_d, out_prec_q;
  logic [TAGW-1:0]       s1_tag_d, s1_tag_q, out_tag_d, out_tag_q;
  logic [NUM_LANES-1:0]  lane_snan;
  logic [NUM_LANES-1:0][63:0] raw;
  logic [NUM_LANES-1:0][15:0] cls;
  logic [NUM_LANES-1:0][52:0] man;

  assign raw = {c_raw, b_raw, a_raw};

  always_comb begin
    s2_load    = ~s2_valid_q | out_ready;
    s1_load    = ~s1_valid_q | s2_load;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s1_prec_d  = (s1_load & in_valid) ? precision : s1_prec_q;
    s1_tag_d   = (s1_load & in_valid) ? in_tag : s1_tag_q;
    out_prec_d = (s2_load & s1_valid_q) ? s1_prec_q : out_prec_q;
    out_tag_d  = (s2_load & s1_valid_q) ? s1_tag_q : out_tag_q;
    // set dominates clear
    snan_d     = (snan_q & ~clr_flags) | (s2_load & s1_valid_q & (|lane_snan));
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fp_unpack_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .s1_en   (s1_load & in_valid),
      .s2_en   (s2_load & s1_valid_q),
      .prec_in (precision),
      .s1_prec (s1_prec_q),
      .raw     (raw[i]),
      .snan    (lane_snan[i]),
      .cls     (cls[i]),
      .man     (man[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_prec_q  <= '0;
      s1_tag_q   <= '0;
      out_prec_q <= '0;
      out_tag_q  <= '0;
      snan_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_prec_q  <= s1_prec_d;
      s1_tag_q   <= s1_tag_d;
      out_prec_q <= out_prec_d;
      out_tag_q  <= out_tag_d;
      snan_q     <= snan_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign out_prec  = out_prec_q;
  assign out_tag   = out_tag_q;
  assign snan_flag = snan_q;
  assign a_cls = cls[0];
  assign b_cls = cls[1];
  assign c_cls = cls[2];
  assign a_man = man[0];
  assign b_man = man[1];
  assign c_man = man[2];
endmodule

// File: tb/tb_fp_operand_unpack.sv
module tb_fp_operand_unpack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  precision = 2'b00;
  logic [3:0]  in_tag = '0;
  logic [63:0] a_raw = '0, b_raw = '0, c_raw = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] a_cls, b_cls, c_cls;
  logic [52:0] a_man, b_man, c_man;
  logic [1:0]  out_prec;
  logic [3:0]  out_tag;
  logic        snan_flag, clr_flags = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_operand_unpack #(.TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .precision(precision), .in_tag(in_tag),
    .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_cls(a_cls), .b_cls(b_cls), .c_cls(c_cls),
    .a_man(a_man), .b_man(b_man), .c_man(c_man),
    .out_prec(out_prec), .out_tag(out_tag),
    .snan_flag(snan_flag), .clr_flags(clr_flags)
  );

  typedef struct {
    logic [3:0]            tag;
    logic [1:0]            prec;
    logic [2:0][15:0]      cls;
    logic [2:0][52:0]      man;
  } exp_t;

  // Reference: field widths per format, then plain arithmetic on the fields.
  function automatic void fmt_widths(input logic [1:0] p, output int eb, output int fb);
    case (p)
      2'b01:   begin eb = 5;  fb = 10; end
      2'b10:   begin eb = 8;  fb = 23; end
      default: begin eb = 11; fb = 52; end
    endcase
  endfunction

  function automatic void ref_unpack(input logic [63:0] raw, input logic [1:0] p,
                                     output logic [15:0] cls, output logic [52:0] man,
                                     output bit snan);
    int eb, fb;
    logic [63:0] e, f, emax;
    bit s, z, n, inf, nan;
    fmt_widths(p, eb, fb);
    emax = (64'd1 << eb) - 64'd1;
    e    = (raw >> fb) & emax;
    f    = raw & ((64'd1 << fb) - 64'd1);
    s    = raw[eb+fb];
    z    = (e == 0) && (f == 0);
    n    = (e != 0) && (e != emax);
    inf  = (e == emax) && (f == 0);
    nan  = (e == emax) && (f != 0);
    cls  = {z, n, inf, nan, s, e[10:0]};
    man  = f[52:0] | (n ? (53'd1 << fb) : 53'd0);
    snan = nan && (f[fb-1] == 1'b0);
  endfunction

  // Random operand biased toward zero/max exponents and zero fractions.
  function automatic logic [63:0] gen_raw(input logic [1:0] p);
    int eb, fb;
    logic [63:0] r, emask, fmask;
    fmt_widths(p, eb, fb);
    r     = {$urandom, $urandom};
    emask = ((64'd1 << eb) - 64'd1) << fb;
    fmask = (64'd1 << fb) - 64'd1;
    case ($urandom % 5)
      0: r = r & ~emask;
      1: r = r | emask;
      2: r = (r | emask) & ~fmask;
      3: r = r & ~emask & ~fmask;
      default: ;
    endcase
    return r;
  endfunction

  function automatic exp_t ref_set(input logic [63:0] a, b, c, input logic [1:0] p,
                                   input logic [3:0] tag);
    exp_t x;
    bit   sn;
    logic [15:0] cl;
    logic [52:0] mn;
    logic [2:0][63:0] ops;
    ops = {c, b, a};
    x.tag = tag;
    x.prec = p;
    for (int k = 0; k < 3; k++) begin
      ref_unpack(ops[k], p, cl, mn, sn);
      x.cls[k] = cl;
      x.man[k] = mn;
    end
    return x;
  endfunction

  // Drive one set, return at the negedge after it reaches the outputs.
  task automatic send(input logic [63:0] a, b, c, input logic [1:0] p,
                      input logic [3:0] tag, input bit clr_at_s2);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; precision = p; in_tag = tag;
    a_raw = a; b_raw = b; c_raw = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clr_flags = clr_at_s2;
    @(posedge clk);
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || snan_flag !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_ctrl: out_valid=%b snan=%b in_ready=%b want 0 0 1",
               out_valid, snan_flag, in_ready);
      errors++;
    end
    checks++;
    if ({a_cls, b_cls, c_cls, a_man, b_man, c_man, out_prec, out_tag} !== '0) begin
      $display("FAIL reset_data: outputs not all zero a_cls=%h a_man=%h tag=%h",
               a_cls, a_man, out_tag);
      errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_classify();
    // prec, operand slot, raw value, expected class word, expected mantissa
    logic [1:0]  tp[8]  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01};
    int          ts[8]  = '{0, 1, 2, 0, 1, 2, 0, 1};
    logic [63:0] tr[8]  = '{64'h3C00, 64'h3F800000, 64'h8000000000000000,
                            64'h7FF0000000000000, 64'h7FC00000, 64'h0001,
                            64'h3FF0000000000000, 64'hDEADBEEF12343C00};
    logic [15:0] tc[8]  = '{16'h400F, 16'h407F, 16'h8800, 16'h27FF,
                            16'h10FF, 16'h0000, 16'h43FF, 16'h400F};
    logic [52:0] tm[8]  = '{53'h400, 53'h800000, 53'h0, 53'h0,
                            53'h400000, 53'h001, 53'h10000000000000, 53'h400};
    for (int i = 0; i < 8; i++) begin
      logic [2:0][63:0] ops;
      logic [2:0][15:0] gc;
      logic [2:0][52:0] gm;
      exp_t x;
      for (int k = 0; k < 3; k++) ops[k] = gen_raw(tp[i]);
      ops[ts[i]] = tr[i];
      x = ref_set(ops[0], ops[1], ops[2], tp[i], 4'(i));
      send(ops[0], ops[1], ops[2], tp[i], 4'(i), 1'b0);
      gc = {c_cls, b_cls, a_cls};
      gm = {c_man, b_man, a_man};
      checks++;
      if (gc[ts[i]] !== tc[i] || gm[ts[i]] !== tm[i]) begin
        $display("FAIL vec%0d_const: cls=%h man=%h want cls=%h man=%h",
                 i, gc[ts[i]], gm[ts[i]], tc[i], tm[i]);
        errors++;
      end
      checks++;
      if (out_valid !== 1'b1 || gc !== x.cls || gm !== x.man ||
          out_tag !== x.tag || out_prec !== x.prec) begin
        $display("FAIL vec%0d_model: v=%b cls=%h tag=%h prec=%b want cls=%h tag=%h prec=%b",
                 i, out_valid, gc, out_tag, out_prec, x.cls, x.tag, x.prec);
        errors++;
      end
    end
  endtask

  task automatic test_snan();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    send(64'h7FC00000, 64'h3F800000, 64'h0, 2'b10, 4'h1, 1'b0);
    checks++;
    if (a_cls !== 16'h10FF || snan_flag !== 1'b0) begin
      $display("FAIL qnan_noflag: cls=%h flag=%b want 10ff 0", a_cls, snan_flag);
      errors++;
    end
    send(64'h7FA00000, 64'h3F800000, 64'h0, 2'b10, 4'h2, 1'b0);
    checks++;
    if (a_cls !== 16'h10FF || snan_flag !== 1'b1) begin
      $display("FAIL snan_set: cls=%h flag=%b want 10ff 1", a_cls, snan_flag);
      errors++;
    end
    // half sNaN in slot b, clear coincident with its capture
    send(64'h0, 64'h7D00, 64'h0, 2'b01, 4'h3, 1'b1);
    checks++;
    if (snan_flag !== 1'b1 || b_cls !== 16'h101F) begin
      $display("FAIL set_over_clr: flag=%b cls=%h want 1 101f", snan_flag, b_cls);
      errors++;
    end
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++;
    if (snan_flag !== 1'b0) begin
      $display("FAIL clr_flags: flag=%b want 0", snan_flag);
      errors++;
    end
  endtask

  task automatic test_stream();
    exp_t q[$];
    exp_t x;
    int   sent = 0, recv = 0, cyc = 0;
    bit   prev_stall = 0;
    logic [2:0][15:0] held_cls;
    logic [3:0]       held_tag;
    logic [63:0]      a, b, c;
    logic [1:0]       p;
    while (recv < 8 && cyc < 400) begin
      @(negedge clk);
      out_ready = ($urandom % 3) != 0;
      in_valid  = (sent < 8) && (($urandom % 4) != 0);
      p = 2'($urandom % 4);
      a = gen_raw(p); b = gen_raw(p); c = gen_raw(p);
      precision = p; in_tag = 4'(sent);
      a_raw = a; b_raw = b; c_raw = c;
      #1;
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        $display("FAIL stream_in_ready: got %b inflight=%0d out_ready=%b",
                 in_ready, q.size(), out_ready);
        errors++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {c_cls, b_cls, a_cls} !== held_cls || out_tag !== held_tag) begin
          $display("FAIL stall_hold: v=%b cls=%h tag=%h want 1 %h %h",
                   out_valid, {c_cls, b_cls, a_cls}, out_tag, held_cls, held_tag);
          errors++;
        end
      end
      if (out_valid && q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_spurious: out_valid=1 with nothing in flight tag=%h", out_tag);
      end else if (out_valid && out_ready) begin
        x = q.pop_front();
        checks++;
        if ({c_cls, b_cls, a_cls} !== x.cls || {c_man, b_man, a_man} !== x.man ||
            out_tag !== x.tag || out_prec !== x.prec) begin
          $display("FAIL stream_data: tag=%h cls=%h prec=%b want tag=%h cls=%h prec=%b",
                   out_tag, {c_cls, b_cls, a_cls}, out_prec, x.tag, x.cls, x.prec);
          errors++;
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      held_cls = {c_cls, b_cls, a_cls};
      held_tag = out_tag;
      if (in_valid && in_ready) begin
        q.push_back(ref_set(a, b, c, p, 4'(sent)));
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8 || q.size() != 0) begin
      $display("FAIL stream_count: received %0d leftover %0d want 8 0", recv, q.size());
      errors++;
    end
  endtask

  task automatic test_rst_midstream();
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; precision = 2'b10; in_tag = 4'h9;
    a_raw = 64'h7FA00000; b_raw = 64'h0; c_raw = 64'h0;
    @(posedge clk);
    @(negedge clk);
    in_tag = 4'hA; a_raw = 64'h3F800000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || snan_flag !== 1'b1 || in_ready !== 1'b0 || out_tag !== 4'h9) begin
      $display("FAIL full_stall: v=%b flag=%b in_ready=%b tag=%h want 1 1 0 9",
               out_valid, snan_flag, in_ready, out_tag);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || snan_flag !== 1'b0) begin
      $display("FAIL async_rst: v=%b flag=%b want 0 0", out_valid, snan_flag);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; precision = 2'b01; in_tag = 4'h3;
    a_raw = 64'h3C00; b_raw = 64'h0; c_raw = 64'h0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL post_rst_lat1: v=%b want 0", out_valid);
      errors++;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a_cls !== 16'h400F || a_man !== 53'h400 || out_tag !== 4'h3) begin
      $display("FAIL post_rst_lat2: v=%b cls=%h man=%h tag=%h want 1 400f 400 3",
               out_valid, a_cls, a_man, out_tag);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_snan();
    test_stream();
    test_rst_midstream();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
